// File: rtl/mas_access_queue_pkg.sv
// rtl/mas_access_queue_pkg.sv - shared types and constants for the access-queue stage
// Default widths and depth, the request word layout {we, addr, wdata} and the
// FSM state encoding. Shared with the servicer tree and the requesters.
package mas_access_queue_pkg;

  localparam int MAS_ADDR_WIDTH = 32;
  localparam int MAS_DATA_WIDTH = 64;
  localparam int MAS_DEPTH      = 4;
  localparam int MAS_TIMEOUT    = 255;

  // Request word as carried on in_data; 'we' is the MSB.
  typedef struct packed {
    logic                      we;
    logic [MAS_ADDR_WIDTH-1:0] addr;
    logic [MAS_DATA_WIDTH-1:0] wdata;
  } mas_req_t;

  typedef enum logic [1:0] {
    MAS_IDLE  = 2'd0,
    MAS_ISSUE = 2'd1,
    MAS_WAIT  = 2'd2
  } mas_state_e;

  // Plain constants with the same encoding as mas_state_e, for the FSM register.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/mas_access_queue_if.sv
// rtl/mas_access_queue_if.sv - tree, memory-port and response bundle of the access queue
// Ports (master = queue side):
//   in_active/in_data in, in_ready out        : request input from the tree
//   mem_req/we/addr/wdata out, mem_ack,
//   mem_rvalid, mem_rdata in                   : single memory port
//   rsp_valid/we/data/err out                  : one-cycle response strobe
//   count out                                  : FIFO occupancy
interface mas_access_queue_if
  import mas_access_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = MAS_ADDR_WIDTH,
  parameter int DATA_WIDTH = MAS_DATA_WIDTH,
  parameter int DEPTH      = MAS_DEPTH
);

  localparam int REQ_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  in_active;
  logic [REQ_WIDTH-1:0]  in_data;
  logic                  in_ready;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_we;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  logic [CNT_WIDTH-1:0]  count;

  modport master (
    input  in_active, in_data, mem_ack, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_we, rsp_data, rsp_err, count
  );

  modport slave (
    output in_active, in_data, mem_ack, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_we, rsp_data, rsp_err, count
  );

endinterface

// File: rtl/mas_access_queue_fifo.sv
// rtl/mas_access_queue_fifo.sv - request FIFO for the access queue
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_push, i_data        : write side (ignored when full)
//   i_pop, o_data         : read side, o_data is the current head (ignored when empty)
//   o_full, o_empty       : registered-count status flags
//   o_count               : occupancy, 0..DEPTH
module mas_access_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mas_access_queue.sv
// rtl/mas_access_queue.sv - buffers tree winners and drives them onto one memory port
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mas_access_queue_if.master
//                in_active/in_data/in_ready   request input with back-pressure
//                mem_req/we/addr/wdata        request held until mem_ack
//                mem_ack/mem_rvalid/mem_rdata memory handshake and read data
//                rsp_valid/we/data/err        one-cycle response strobe
//                count                        FIFO occupancy
module mas_access_queue
  import mas_access_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = MAS_ADDR_WIDTH,
  parameter int DATA_WIDTH = MAS_DATA_WIDTH,
  parameter int DEPTH      = MAS_DEPTH,
  parameter int TIMEOUT    = MAS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  mas_access_queue_if.master bus
);

  localparam int REQ_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [REQ_WIDTH-1:0]  w_head;
  logic [CNT_WIDTH-1:0]  w_count;
  logic [7:0]            w_timer_inc;

  logic [1:0]            r_state;
  logic [7:0]            r_timer;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_we;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;

  // in_ready comes from the registered count only, so a pop in the same
  // cycle never frees a slot for a push at full.
  assign w_push = bus.in_active && !w_full;
  // Popping only from IDLE forces one idle cycle between transactions.
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;
  assign w_timer_inc = r_timer + 8'd1;

  mas_access_queue_fifo #(
    .WIDTH (REQ_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Response flags are pulses: cleared unless set again below.
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_mem_we    <= w_head[REQ_WIDTH-1];
            r_mem_addr  <= w_head[DATA_WIDTH +: ADDR_WIDTH];
            r_mem_wdata <= w_head[DATA_WIDTH-1:0];
            r_mem_req   <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_rsp_valid <= 1'b1;
              r_rsp_we    <= 1'b1;
              r_rsp_data  <= '0;
              r_state     <= ST_IDLE;
            end else if (bus.mem_rvalid) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= bus.mem_rdata;
              r_state     <= ST_IDLE;
            end else begin
              r_timer <= '0;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.mem_rdata;
            r_state     <= ST_IDLE;
          end else if (w_timer_inc == TIMEOUT_LIM) begin
            // Abort after TIMEOUT waiting cycles; a late rvalid is then ignored.
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_timer     <= w_timer_inc;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_we    = r_rsp_we;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.count     = w_count;

endmodule

// File: tb/tb_mas_access_queue.sv
// tb/tb_mas_access_queue.sv - self-checking bench for mas_access_queue
module tb_mas_access_queue;
  import mas_access_queue_pkg::*;

  localparam int TO = MAS_TIMEOUT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  mas_req_t exp_q[$];

  mas_access_queue_if #(
    .ADDR_WIDTH (MAS_ADDR_WIDTH),
    .DATA_WIDTH (MAS_DATA_WIDTH),
    .DEPTH      (MAS_DEPTH)
  ) bus ();

  mas_access_queue #(
    .ADDR_WIDTH (MAS_ADDR_WIDTH),
    .DATA_WIDTH (MAS_DATA_WIDTH),
    .DEPTH      (MAS_DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Memory contents seen by reads: a fixed function of the address.
  function automatic logic [63:0] rd_model(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_C3C3};
  endfunction

  function automatic mas_req_t rand_req();
    mas_req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = $urandom;
    r.wdata = {$urandom, $urandom};
    return r;
  endfunction

  task automatic push_word(input mas_req_t r);
    bit done;
    done = 1'b0;
    bus.in_active = 1'b1;
    bus.in_data   = r;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready === 1'b1) done = 1'b1;
      step();
    end
    bus.in_active = 1'b0;
    chk("push_accept", done, 1'b1);
    if (done) exp_q.push_back(r);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.mem_req === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  // Serve the oldest expected request. rv_dly = 0: rvalid with ack;
  // otherwise rvalid sampled rv_dly edges after the ack edge.
  task automatic serve_one(input int ack_dly, input int rv_dly);
    bit ok;
    mas_req_t e;
    wait_req(ok);
    chk("req_seen", ok, 1'b1);
    if (ok && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_we", bus.mem_we, e.we);
      chk("mem_addr", bus.mem_addr, e.addr);
      if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
      for (int i = 0; i < ack_dly; i++) begin
        step();
        chk("req_held", bus.mem_req, 1'b1);
        chk("addr_stable", bus.mem_addr, e.addr);
      end
      bus.mem_ack = 1'b1;
      if (!e.we && rv_dly == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd_model(e.addr);
      end
      step();
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      chk("req_drop", bus.mem_req, 1'b0);
      if (!e.we && rv_dly > 0) begin
        chk("no_early_rsp", bus.rsp_valid, 1'b0);
        for (int i = 1; i < rv_dly; i++) step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd_model(e.addr);
        step();
        bus.mem_rvalid = 1'b0;
      end
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_we", bus.rsp_we, e.we);
      chk("rsp_data", bus.rsp_data, e.we ? 64'd0 : rd_model(e.addr));
      chk("rsp_err", bus.rsp_err, 1'b0);
      step();
      chk("rsp_pulse", bus.rsp_valid, 1'b0);
    end
  endtask

  initial begin
    mas_req_t r;
    mas_req_t w6;
    bit ok;
    bit early;
    int k;

    bus.in_active  = 1'b0;
    bus.in_data    = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_count", bus.count, 3'd0);
    rst_n = 1'b1;
    step();

    // Single read with exact latency
    r.we = 1'b0; r.addr = 32'h100; r.wdata = {$urandom, $urandom};
    bus.in_active = 1'b1; bus.in_data = r;
    step();
    bus.in_active = 1'b0;
    chk("t1_count", bus.count, 3'd1);
    chk("t1_req_early", bus.mem_req, 1'b0);
    step();
    chk("t1_req", bus.mem_req, 1'b1);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_we", bus.mem_we, 1'b0);
    chk("t1_count_pop", bus.count, 3'd0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t1_req_drop", bus.mem_req, 1'b0);
    chk("t1_no_rsp", bus.rsp_valid, 1'b0);
    step();
    chk("t1_wait", bus.rsp_valid, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBEEF;
    step();
    bus.mem_rvalid = 1'b0;
    chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("t1_rsp_data", bus.rsp_data, 64'hBEEF);
    chk("t1_rsp_we", bus.rsp_we, 1'b0);
    chk("t1_rsp_err", bus.rsp_err, 1'b0);
    step();
    chk("t1_pulse", bus.rsp_valid, 1'b0);

    // Write acked in the first request cycle
    r.we = 1'b1; r.addr = 32'h20; r.wdata = 64'h55;
    push_word(r);
    serve_one(0, 0);

    // Read with ack and rvalid together, then a back-to-back read
    r.we = 1'b0; r.addr = $urandom;
    push_word(r);
    serve_one(1, 0);
    r.addr = $urandom;
    push_word(r);
    serve_one(0, 0);

    // Fill to full; sixth word held by the source until the first pop
    for (int i = 0; i < 5; i++) push_word(rand_req());
    chk("fill_count", bus.count, 3'd4);
    chk("fill_ready", bus.in_ready, 1'b0);
    chk("fill_req", bus.mem_req, 1'b1);
    w6 = rand_req();
    bus.in_active = 1'b1; bus.in_data = w6;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_count", bus.count, 3'd4);
      chk("full_ready", bus.in_ready, 1'b0);
    end
    serve_one($urandom_range(0, 2), $urandom_range(0, 3));
    chk("after_pop_count", bus.count, 3'd3);
    chk("after_pop_ready", bus.in_ready, 1'b1);
    step();
    bus.in_active = 1'b0;
    exp_q.push_back(w6);
    chk("refill_count", bus.count, 3'd4);
    for (int i = 0; i < 5; i++) serve_one($urandom_range(0, 3), $urandom_range(0, 4));

    // Read timeout, then a stray rvalid
    r.we = 1'b0; r.addr = $urandom;
    push_word(r);
    void'(exp_q.pop_front());
    wait_req(ok);
    chk("to_req", ok, 1'b1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i < TO && bus.rsp_valid === 1'b1) early = 1'b1;
    end
    chk("to_early", early, 1'b0);
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_rsp_err", bus.rsp_err, 1'b1);
    chk("to_rsp_data", bus.rsp_data, 64'd0);
    chk("to_rsp_we", bus.rsp_we, 1'b0);
    step();
    chk("to_pulse", bus.rsp_valid, 1'b0);
    chk("to_err_pulse", bus.rsp_err, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
    step();
    bus.mem_rvalid = 1'b0;
    chk("stray_rsp", bus.rsp_valid, 1'b0);
    chk("stray_req", bus.mem_req, 1'b0);
    step();
    chk("stray_rsp2", bus.rsp_valid, 1'b0);

    // Randomized batches against the in-order model
    for (int round = 0; round < 8; round++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) push_word(rand_req());
      for (int j = 0; j < k; j++) serve_one($urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Reset while waiting for read data with three queued
    for (int i = 0; i < 4; i++) begin
      r.we = 1'b0; r.addr = $urandom;
      push_word(r);
    end
    wait_req(ok);
    chk("rst_t_req", ok, 1'b1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("rst_t_count", bus.count, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_t_mem_req", bus.mem_req, 1'b0);
    chk("rst_t_count0", bus.count, 3'd0);
    chk("rst_t_ready", bus.in_ready, 1'b1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_ack = 1'b1;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_ack = 1'b0;
    chk("post_rst_rsp", bus.rsp_valid, 1'b0);
    chk("post_rst_req", bus.mem_req, 1'b0);
    step();
    chk("post_rst_rsp2", bus.rsp_valid, 1'b0);
    chk("post_rst_count", bus.count, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
